// File: rtl/mult_pkg.sv
// Shared definitions for the iterative multiply sequencer.
//   state_t     : FSM encoding (IDLE / RUN / FIX), 2 bits
//   CYCLES      : RUN cycles for the default configuration
//   mult_cycles : RUN cycles for a given operand width and step size
//   cnt_width   : width of a counter that must hold the value CYCLES
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_STEP_BITS = 1;
    localparam int CYCLES        = DEF_WIDTH / DEF_STEP_BITS;

    function automatic int mult_cycles(input int width, input int step_bits);
        return width / step_bits;
    endfunction

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration of the multiplier (purely combinational).
// Ports:
//   i_acc    : running 2*WIDTH accumulator
//   i_mcand  : multiplicand, already aligned to the current bit position
//   i_mplier : remaining multiplier bits; the low STEP_BITS are retired here
//   o_acc    : accumulator plus this step's partial product
//   o_mcand  : multiplicand aligned for the next step
//   o_mplier : multiplier with the retired bits shifted out
module mult_step
    import mult_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int STEP_BITS = DEF_STEP_BITS
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [2*WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0]   i_mplier,
    output logic [2*WIDTH-1:0] o_acc,
    output logic [2*WIDTH-1:0] o_mcand,
    output logic [WIDTH-1:0]   o_mplier
);

    logic [STEP_BITS-1:0] w_slice;
    logic [2*WIDTH-1:0]   w_partial;

    assign w_slice   = i_mplier[STEP_BITS-1:0];
    // Small-radix partial product: slice is at most 4 bits wide.
    assign w_partial = i_mcand * {{(2*WIDTH-STEP_BITS){1'b0}}, w_slice};
    assign o_acc     = i_acc + w_partial;
    assign o_mcand   = i_mcand << STEP_BITS;
    assign o_mplier  = i_mplier >> STEP_BITS;

endmodule

// File: rtl/mult_sequencer.sv
// Sequencer for the iterative mult/multu unit behind the EX stage.
// Latches operands on start_mult, runs WIDTH/STEP_BITS shift-add cycles,
// then a sign-fix cycle that writes HI/LO and pulses done.
// Ports:
//   clk, reset            : clock, async active-high reset
//   start_mult, mult_sign : issue mult (sign=1) / multu (sign=0)
//   srca, srcb            : multiplicand / multiplier
//   read_hilo             : mfhi/mflo in EX this cycle
//   busy                  : state != IDLE (registered)
//   stall                 : hold IF/ID/EX while a product is pending
//   done                  : one-cycle pulse after HI/LO update
//   hi, lo                : HI/LO registers
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int STEP_BITS = DEF_STEP_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             read_hilo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int L_CYCLES = mult_cycles(WIDTH, STEP_BITS);
    localparam int CW       = cnt_width(L_CYCLES);

    state_t             r_state;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_mcand_next;
    logic [WIDTH-1:0]   w_mplier_next;
    logic [2*WIDTH-1:0] w_product;

    // Signed operands are stored as magnitudes; the most negative value
    // negates to itself, which is exactly its magnitude read as unsigned.
    assign w_a_neg   = mult_sign & srca[WIDTH-1];
    assign w_b_neg   = mult_sign & srcb[WIDTH-1];
    assign w_a_mag   = w_a_neg ? -srca : srca;
    assign w_b_mag   = w_b_neg ? -srcb : srcb;
    assign w_product = r_neg ? -r_acc : r_acc;

    mult_step #(
        .WIDTH     (WIDTH),
        .STEP_BITS (STEP_BITS)
    ) u_step (
        .i_acc    (r_acc),
        .i_mcand  (r_mcand),
        .i_mplier (r_mplier),
        .o_acc    (w_acc_next),
        .o_mcand  (w_mcand_next),
        .o_mplier (w_mplier_next)
    );

    // A new start wins in every state: an operation in flight is dropped
    // without touching HI/LO (later mult overwrites an earlier one).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            if (start_mult) begin
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                r_mplier <= w_b_mag;
                r_neg    <= w_a_neg ^ w_b_neg;
                r_count  <= CW'(L_CYCLES);
                r_state  <= RUN;
                r_busy   <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_busy <= 1'b0;
                    end
                    RUN: begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= w_mcand_next;
                        r_mplier <= w_mplier_next;
                        r_count  <= r_count - CW'(1);
                        if (r_count == CW'(1)) begin
                            r_state <= FIX;
                        end
                    end
                    FIX: begin
                        {r_hi, r_lo} <= w_product;
                        r_done       <= 1'b1;
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A read issued alongside a start is the younger instruction, so it waits.
    assign stall = read_hilo & (r_busy | start_mult);
    assign busy  = r_busy;
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_mult_sequencer.sv
module tb_mult_sequencer;

    logic        clk;
    logic        reset;
    logic        start_mult;
    logic        mult_sign;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        read_hilo;

    logic        busy_o  [3];
    logic        stall_o [3];
    logic        done_o  [3];
    logic [31:0] hi_o    [3];
    logic [31:0] lo_o    [3];

    int          steps   [3] = '{1, 2, 4};

    int          n_checks = 0;
    int          n_fail   = 0;

    int          got_lat  [3];
    logic [63:0] got_res  [3];
    int          done_cnt [3];
    int          busy_cycles;

    mult_sequencer #(.WIDTH(32), .STEP_BITS(1)) u_s1 (
        .clk(clk), .reset(reset), .start_mult(start_mult), .mult_sign(mult_sign),
        .srca(srca), .srcb(srcb), .read_hilo(read_hilo),
        .busy(busy_o[0]), .stall(stall_o[0]), .done(done_o[0]), .hi(hi_o[0]), .lo(lo_o[0])
    );
    mult_sequencer #(.WIDTH(32), .STEP_BITS(2)) u_s2 (
        .clk(clk), .reset(reset), .start_mult(start_mult), .mult_sign(mult_sign),
        .srca(srca), .srcb(srcb), .read_hilo(read_hilo),
        .busy(busy_o[1]), .stall(stall_o[1]), .done(done_o[1]), .hi(hi_o[1]), .lo(lo_o[1])
    );
    mult_sequencer #(.WIDTH(32), .STEP_BITS(4)) u_s4 (
        .clk(clk), .reset(reset), .start_mult(start_mult), .mult_sign(mult_sign),
        .srca(srca), .srcb(srcb), .read_hilo(read_hilo),
        .busy(busy_o[2]), .stall(stall_o[2]), .done(done_o[2]), .hi(hi_o[2]), .lo(lo_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference product: plain 64-bit integer arithmetic.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Issue one operation and watch all three instances for 40 cycles.
    // Sample index n counts rising edges after the start edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        @(negedge clk);
        start_mult = 1'b1;
        srca       = a;
        srcb       = b;
        mult_sign  = sgn;
        @(negedge clk);
        start_mult  = 1'b0;
        busy_cycles = busy_o[0] ? 1 : 0;
        for (int k = 0; k < 3; k++) begin
            got_lat[k]  = -1;
            got_res[k]  = 'x;
            done_cnt[k] = 0;
        end
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy_o[0]) busy_cycles++;
            for (int k = 0; k < 3; k++) begin
                if (done_o[k]) begin
                    if (done_cnt[k] == 0) begin
                        got_lat[k] = n;
                        got_res[k] = {hi_o[k], lo_o[k]};
                    end
                    done_cnt[k]++;
                end
            end
        end
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic sgn, input logic [63:0] exp);
        run_op(a, b, sgn);
        chk({tag, "_res"},  got_res[0], exp);
        chk({tag, "_lat"},  64'(got_lat[0]), 64'd33);
        chk({tag, "_done"}, 64'(done_cnt[0]), 64'd1);
    endtask

    initial begin
        logic [63:0] prior;
        logic [31:0] ra, rb;
        logic        rs;
        logic        stall_ok;
        logic        hold_ok;
        int          m_done;
        int          first_dones;

        reset      = 1'b1;
        start_mult = 1'b0;
        mult_sign  = 1'b0;
        srca       = '0;
        srcb       = '0;
        read_hilo  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_busy",  64'(busy_o[0]), 64'd0);
        chk("rst_done",  64'(done_o[0]), 64'd0);
        chk("rst_hilo",  {hi_o[0], lo_o[0]}, 64'd0);
        chk("rst_stall", 64'(stall_o[0]), 64'd0);

        // Basic unsigned: also check busy length and single-cycle done.
        run_op(32'd3, 32'd5, 1'b0);
        chk("multu3x5_res",  got_res[0], 64'h0000000F);
        chk("multu3x5_lat",  64'(got_lat[0]), 64'd33);
        chk("multu3x5_busy", 64'(busy_cycles), 64'd33);
        chk("multu3x5_done", 64'(done_cnt[0]), 64'd1);

        directed("multu_max",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001);
        directed("mult_m1m1",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001);
        directed("mult_min_1",  32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000);
        directed("mult_minmin", 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);

        // Stall: read coinciding with start, then read held from cycle 2.
        @(negedge clk);
        start_mult = 1'b1;
        srca       = 32'd7;
        srcb       = 32'd6;
        mult_sign  = 1'b1;
        read_hilo  = 1'b1;
        #1;
        chk("stall_with_start", 64'(stall_o[0]), 64'd1);
        @(negedge clk);
        start_mult = 1'b0;
        read_hilo  = 1'b0;
        stall_ok   = 1'b1;
        for (int n = 1; n <= 33; n++) begin
            @(negedge clk);
            if (n >= 2) read_hilo = 1'b1;
            #1;
            if (n >= 2 && n < 33 && stall_o[0] !== 1'b1) stall_ok = 1'b0;
            if (n == 33) begin
                chk("stall_done",      64'(done_o[0]), 64'd1);
                chk("stall_done_low",  64'(stall_o[0]), 64'd0);
                chk("stall_done_lo",   64'(lo_o[0]), 64'h2A);
            end
        end
        read_hilo = 1'b0;
        chk("stall_held", 64'(stall_ok), 64'd1);

        // Restart: multu 2,2 then multu 9,9 on the tenth edge after the first start.
        prior = {hi_o[0], lo_o[0]};
        @(negedge clk);
        start_mult  = 1'b1;
        srca        = 32'd2;
        srcb        = 32'd2;
        mult_sign   = 1'b0;
        @(negedge clk);
        start_mult  = 1'b0;
        first_dones = 0;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (done_o[0]) first_dones++;
        end
        start_mult = 1'b1;
        srca       = 32'd9;
        srcb       = 32'd9;
        @(negedge clk);
        start_mult = 1'b0;
        hold_ok    = 1'b1;
        m_done     = -1;
        for (int m = 1; m <= 40; m++) begin
            @(negedge clk);
            if (done_o[0]) begin
                if (m_done < 0) begin
                    m_done = m;
                    chk("restart_lo", 64'(lo_o[0]), 64'h51);
                end
                first_dones++;
            end else if (m_done < 0 && {hi_o[0], lo_o[0]} !== prior) begin
                hold_ok = 1'b0;
            end
        end
        chk("restart_lat",   64'(m_done), 64'd33);
        chk("restart_dones", 64'(first_dones), 64'd1);
        chk("restart_hold",  64'(hold_ok), 64'd1);

        // Reset in the middle of RUN.
        @(negedge clk);
        start_mult = 1'b1;
        srca       = 32'd2;
        srcb       = 32'd3;
        mult_sign  = 1'b0;
        @(negedge clk);
        start_mult = 1'b0;
        for (int n = 1; n <= 15; n++) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy_o[0]), 64'd0);
        chk("midrst_done", 64'(done_o[0]), 64'd0);
        chk("midrst_hilo", {hi_o[0], lo_o[0]}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        directed("after_rst", 32'd4, 32'd4, 1'b0, 64'h10);

        // Randomised pairs, all three step sizes side by side.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 7))
                0: ra = 32'h80000000;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h7FFFFFFF;
                3: rb = 32'd0;
                default: ;
            endcase
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("rnd%0d_s%0d_res", i, steps[k]), got_res[k], ref_mul(ra, rb, rs));
                chk($sformatf("rnd%0d_s%0d_lat", i, steps[k]), 64'(got_lat[k]),
                    64'(32 / steps[k] + 1));
                chk($sformatf("rnd%0d_s%0d_dones", i, steps[k]), 64'(done_cnt[k]), 64'd1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
